// File: rtl/pixel_readout_pkg.sv
// Shared types and constants for the pixel readout block.
// Optional feature macro: PIXEL_READOUT_CHECKSUM_EN appends a checksum byte
// (sum of the four pixels, mod 256) after pixel 4 of every word.
package pixel_readout_pkg;

  localparam int PIX_W  = 8;
  localparam int N_PIX  = 4;
  localparam int WORD_W = N_PIX * PIX_W;
  localparam int IDX_W  = 3;

  // Pixel 1 sits in the least significant byte.
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } ser_state_t;

`ifdef PIXEL_READOUT_CHECKSUM_EN
  // Index of the final byte of a word: the checksum byte.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX);

  // Modulo-256 sum of all pixels in a word.
  function automatic logic [PIX_W-1:0] pix_sum(input word_t w);
    logic [PIX_W-1:0] s;
    s = '0;
    for (int i = 0; i < N_PIX; i++) s = s + w[i*PIX_W +: PIX_W];
    return s;
  endfunction
`else
  // Index of the final byte of a word: pixel 4.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);
`endif

endpackage

// File: rtl/pixel_readout_if.sv
// Pixel capture inputs and byte-stream outputs of the readout block.
// master: the environment (pixel array, downstream sink); slave: the readout.
interface pixel_readout_if;
  import pixel_readout_pkg::*;

  logic             read;
  logic [PIX_W-1:0] pix_data1;
  logic [PIX_W-1:0] pix_data2;
  logic [PIX_W-1:0] pix_data3;
  logic [PIX_W-1:0] pix_data4;
  logic             ovf_clr;
  logic             out_ready;
  logic             out_valid;
  logic [PIX_W-1:0] out_data;
  logic             out_sof;
  logic             out_eof;
  logic             overflow;

  modport master (
    output read, pix_data1, pix_data2, pix_data3, pix_data4, ovf_clr, out_ready,
    input  out_valid, out_data, out_sof, out_eof, overflow
  );

  modport slave (
    input  read, pix_data1, pix_data2, pix_data3, pix_data4, ovf_clr, out_ready,
    output out_valid, out_data, out_sof, out_eof, overflow
  );

endinterface

// File: rtl/pixel_readout_fifo.sv
// Word FIFO between capture and serializer, first-word fall-through.
// Push while full and pop while empty are ignored.
module pixel_readout_fifo
  import pixel_readout_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  word_t din,
  output logic  full,
  output logic  empty,
  output word_t dout
);

  localparam int AW = $clog2(DEPTH);

  word_t          r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage array: written on accepted push.
  // NOTE: the data array has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; power-of-2 depth lets pointers wrap naturally.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_readout.sv
// Pixel readout: captures one 4-pixel word per read phase into a FIFO and
// serializes it as a byte stream with valid/ready handshake.
// Optional feature macro: PIXEL_READOUT_CHECKSUM_EN adds a fifth checksum byte.
module pixel_readout
  import pixel_readout_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  pixel_readout_if.slave bus
);

  // Capture tracking
  logic             r_rd_seen;   // read was high on the previous edge of this phase
  logic             r_done;      // this phase already produced its word
  logic             r_overflow;
  logic             w_capture;

  // FIFO connection
  word_t            w_word_in;
  word_t            w_fifo_dout;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  // Serializer
  ser_state_t       r_state;
  word_t            r_word;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_next_idx;
  logic             r_valid;
  logic [PIX_W-1:0] r_data;
  logic             r_sof;
  logic             r_eof;
  logic             w_xfer;

  // Byte at position idx of a word: pixels in order, then the optional checksum.
  function automatic logic [PIX_W-1:0] f_byte(input word_t w, input logic [IDX_W-1:0] idx);
`ifdef PIXEL_READOUT_CHECKSUM_EN
    if (idx == IDX_W'(N_PIX)) return pix_sum(w);
`endif
    return w[idx*PIX_W +: PIX_W];
  endfunction

  // The first edge of a phase lets the buses settle; the second one samples.
  assign w_capture = bus.read && r_rd_seen && !r_done;
  assign w_word_in = {bus.pix_data4, bus.pix_data3, bus.pix_data2, bus.pix_data1};
  assign w_push    = w_capture && !w_full;

  assign w_xfer     = r_valid && bus.out_ready;
  assign w_next_idx = r_idx + IDX_W'(1);
  // Load a new word when idle, or right as the last byte leaves (no bubble).
  assign w_pop      = !w_empty && ((r_state == S_IDLE) || (w_xfer && r_idx == LAST_IDX));

  pixel_readout_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_word_in),
    .full  (w_full),
    .empty (w_empty),
    .dout  (w_fifo_dout)
  );

  // Read-phase tracking: one capture per phase, re-armed only by read going low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_seen <= 1'b0;
      r_done    <= 1'b0;
    end else if (!bus.read) begin
      r_rd_seen <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rd_seen <= 1'b1;
      if (r_rd_seen) r_done <= 1'b1;
    end
  end

  // Sticky overflow; a drop on the same edge as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      r_overflow <= 1'b0;
    else if (w_capture && w_full)   r_overflow <= 1'b1;
    else if (bus.ovf_clr)           r_overflow <= 1'b0;
  end

  // Serializer FSM with registered stream outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (w_pop) begin
      r_state <= S_SEND;
      r_word  <= w_fifo_dout;
      r_idx   <= '0;
      r_valid <= 1'b1;
      r_data  <= w_fifo_dout[PIX_W-1:0];
      r_sof   <= 1'b1;
      r_eof   <= 1'b0;
    end else if (r_state == S_SEND && w_xfer) begin
      if (r_idx == LAST_IDX) begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
        r_data  <= '0;
        r_sof   <= 1'b0;
        r_eof   <= 1'b0;
      end else begin
        r_idx   <= w_next_idx;
        r_data  <= f_byte(r_word, w_next_idx);
        r_sof   <= 1'b0;
        r_eof   <= (w_next_idx == LAST_IDX);
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_sof   = r_sof;
  assign bus.out_eof   = r_eof;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_pixel_readout.sv
// Directed self-checking bench for pixel_readout (FIFO_DEPTH = 4).
// Honors PIXEL_READOUT_CHECKSUM_EN to expect the fifth checksum byte.
`timescale 1ns/1ps
module tb_pixel_readout;

  typedef logic [3:0][7:0] pix4_t;   // [0] = pixel 1

`ifdef PIXEL_READOUT_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  pixel_readout_if bus ();

  pixel_readout #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic pix4_t mk(input logic [7:0] a, b, c, d);
    pix4_t p;
    p[0] = a; p[1] = b; p[2] = c; p[3] = d;
    return p;
  endfunction

  // Distinct pattern for word k: pixel i = k*16 + i.
  function automatic pix4_t wpat(input int k);
    return mk(8'(k*16 + 1), 8'(k*16 + 2), 8'(k*16 + 3), 8'(k*16 + 4));
  endfunction

  // Expected byte i of a word: pixels, then mod-256 sum.
  function automatic logic [7:0] exp_byte(input pix4_t p, input int i);
    logic [7:0] s;
    if (i < 4) return p[i];
    s = p[0] + p[1] + p[2] + p[3];
    return s;
  endfunction

  task automatic drive(input pix4_t p);
    bus.pix_data1 = p[0];
    bus.pix_data2 = p[1];
    bus.pix_data3 = p[2];
    bus.pix_data4 = p[3];
  endtask

  // Read high for n edges, then low for one edge.
  task automatic read_phase(input int n, input pix4_t p);
    drive(p);
    bus.read = 1'b1;
    repeat (n) tick();
    bus.read = 1'b0;
    tick();
  endtask

  // Wait up to budget cycles for valid, then check bytes start..NB-1 (out_ready high).
  task automatic recv_from(input string tag, input pix4_t p, input int start, input int budget);
    int w = 0;
    while (!bus.out_valid && w < budget) begin
      tick();
      w++;
    end
    for (int i = start; i < NB; i++) begin
      check($sformatf("%s_valid%0d", tag, i), bus.out_valid, 1);
      check($sformatf("%s_data%0d", tag, i), bus.out_data, exp_byte(p, i));
      check($sformatf("%s_sof%0d", tag, i), bus.out_sof, (i == 0) ? 1 : 0);
      check($sformatf("%s_eof%0d", tag, i), bus.out_eof, (i == NB - 1) ? 1 : 0);
      tick();
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_sof"}, bus.out_sof, 0);
    check({tag, "_eof"}, bus.out_eof, 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check_idle(tag);
    check({tag, "_data"}, bus.out_data, 0);
    check({tag, "_ovf"}, bus.overflow, 0);
  endtask

  initial begin
    pix4_t p, q;

    reset         = 1'b1;
    bus.read      = 1'b0;
    bus.ovf_clr   = 1'b0;
    bus.out_ready = 1'b1;
    drive(mk(8'h00, 8'h00, 8'h00, 8'h00));
    repeat (2) tick();
    check_reset_outs("rst");
    reset = 1'b0;
    tick();

    // Basic word, read high 3 cycles; valid exactly one edge after the capture edge.
    p = mk(8'h11, 8'h22, 8'h33, 8'h44);
    drive(p);
    bus.read = 1'b1;
    tick();
    check("lat_e1", bus.out_valid, 0);
    tick();
    check("lat_cap", bus.out_valid, 0);
    tick();
    bus.read = 1'b0;
    recv_from("w1", p, 0, 0);
    check_idle("w1_end");

    // All-ones word; checksum byte wraps to 0xFC.
    p = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    read_phase(2, p);
    recv_from("wff", p, 0, 4);
`ifdef PIXEL_READOUT_CHECKSUM_EN
    check("wff_sum_const", 32'(exp_byte(p, 4)), 32'h0000_00FC);
`endif
    check_idle("wff_end");

    // Stall for 5 cycles on byte 2; data must hold.
    p = mk(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    read_phase(2, p);
    check("stall_b0", bus.out_data, 8'hA1);
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_hold_v%0d", i), bus.out_valid, 1);
      check($sformatf("stall_hold_d%0d", i), bus.out_data, 8'hB2);
      check($sformatf("stall_hold_s%0d", i), bus.out_sof, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    recv_from("stall", p, 1, 0);
    check_idle("stall_end");

    // Fill: 1 word in serializer + 4 in FIFO, then drops.
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) read_phase(2, wpat(k));
    check("fill_no_ovf", bus.overflow, 0);
    check("fill_head", bus.out_data, 8'h11);
    read_phase(2, wpat(6));
    check("drop6_ovf", bus.overflow, 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_clr", bus.overflow, 0);
    // Clear on the same edge as a drop: overflow stays set.
    drive(wpat(7));
    bus.read = 1'b1;
    tick();
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    bus.read = 1'b0;
    tick();
    check("drop_vs_clr", bus.overflow, 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_clr2", bus.overflow, 0);
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) recv_from($sformatf("drain%0d", k), wpat(k), 0, 0);
    check_idle("drain_end");
    repeat (4) tick();
    check_idle("drain_none");

    // Single-cycle read phase: no capture.
    bus.read = 1'b1;
    tick();
    bus.read = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("short_%0d", i), bus.out_valid, 0);
    end

    // Back-to-back: second word captured while first streams; no gap.
    p = mk(8'h01, 8'h02, 8'h03, 8'h04);
    q = mk(8'h80, 8'h90, 8'hA0, 8'hB0);
    read_phase(2, p);
    fork
      read_phase(2, q);
      recv_from("b2b_a", p, 0, 0);
    join
    recv_from("b2b_b", q, 0, 0);
    check_idle("b2b_end");

    // Reset during byte 2 with another word buffered.
    bus.out_ready = 1'b0;
    read_phase(2, wpat(3));
    read_phase(2, wpat(4));
    bus.out_ready = 1'b1;
    tick();
    check("pre_rst_b1", bus.out_data, 8'h32);
    reset = 1'b1;
    #1;
    check_reset_outs("rst_mid");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("post_rst_%0d", i), bus.out_valid, 0);
    end

    // Read held high across reset release: capture needs two edges after release.
    p = mk(8'h5A, 8'hA5, 8'h3C, 8'hC3);
    drive(p);
    bus.read = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rel_e1", bus.out_valid, 0);
    tick();
    check("rel_cap", bus.out_valid, 0);
    bus.read = 1'b0;
    tick();
    recv_from("rel", p, 0, 0);
    check_idle("rel_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
